sobol_seq_gen: RTL and testbench

Generates one dimension of a Sobol low-discrepancy sequence as unsigned 32-bit fixed-point integers (binary point left of bit 31), using the Antonov–Saleev Gray-code recurrence over a loadable direction-number table. It sits directly upstream of the INT32-to-FP16 converter: `out_data` drives that converter's 32-bit integer input. Points are delivered over a valid/ready stream at one point per cycle under no backpressure.

---
 rtl/sobol_pkg.sv | 22 ++
 rtl/sobol_lowest_zero.sv | 19 +
 rtl/sobol_seq_gen.sv | 105 ++++++++++
 tb/tb_sobol_seq_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sobol_pkg.sv
// Shared constants, FSM state encoding and default direction numbers for the
// Sobol sequence generator.
package sobol_pkg;

    localparam int SOBOL_W     = 32;
    localparam int SOBOL_DEPTH = 32;
    localparam int SOBOL_AW    = $clog2(SOBOL_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_DONE = 2'd2
    } sobol_state_e;

    // Default table makes the generator emit the Van der Corput sequence.
    function automatic logic [SOBOL_W-1:0] sobol_default_dir(input int k);
        logic [SOBOL_W-1:0] msb;
        msb = {1'b1, {(SOBOL_W-1){1'b0}}};
        return msb >> k;
    endfunction

endpackage

// File: rtl/sobol_lowest_zero.sv
// Combinational priority encoder: index of the lowest zero bit of n.
import sobol_pkg::*;

module sobol_lowest_zero (
    input  logic [SOBOL_W-1:0]  n,
    output logic [SOBOL_AW-1:0] idx
);

    // Scan from the top so the lowest zero bit wins the last assignment.
    always_comb begin
        idx = '0;
        for (int i = SOBOL_W - 1; i >= 0; i--) begin
            if (!n[i]) begin
                idx = SOBOL_AW'(i);
            end
        end
    end

endmodule

// File: rtl/sobol_seq_gen.sv
// One dimension of a Sobol sequence via the Antonov-Saleev Gray-code recurrence,
// streamed over valid/ready with one point per cycle.
import sobol_pkg::*;

module sobol_seq_gen #(
    parameter int W     = SOBOL_W,
    parameter int DEPTH = SOBOL_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dir_we,
    input  logic [$clog2(DEPTH)-1:0] dir_addr,
    input  logic [W-1:0]             dir_wdata,
    input  logic                     start,
    input  logic [31:0]              num_pts,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    sobol_state_e        state_q, state_d;
    logic [W-1:0]        x_q, x_d;
    logic [31:0]         n_q, n_d;
    logic [31:0]         npts_q, npts_d;
    logic [W-1:0]        dir_q [DEPTH];
    logic [W-1:0]        dir_d [DEPTH];
    logic [SOBOL_AW-1:0] c_idx;

    sobol_lowest_zero u_lowest_zero (
        .n   (n_q),
        .idx (c_idx)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        npts_d  = npts_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (dir_we) begin
                    dir_d[dir_addr] = dir_wdata;
                end
                // x_1 reads dir_q, so a same-cycle write to v[0] is not seen yet.
                if (start) begin
                    npts_d = num_pts;
                    if (num_pts != 32'd0) begin
                        state_d = ST_OUT;
                        x_d     = dir_q[0];
                        n_d     = 32'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (n_q == npts_q) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d = x_q ^ dir_q[c_idx];
                        n_d = n_q + 32'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            n_q     <= '0;
            npts_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dir_q[k] <= sobol_default_dir(k);
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            npts_q  <= npts_d;
            for (int k = 0; k < DEPTH; k++) begin
                dir_q[k] <= dir_d[k];
            end
        end
    end

    assign out_valid = (state_q == ST_OUT);
    assign out_data  = x_q;
    assign out_last  = (state_q == ST_OUT) && (n_q == npts_q);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sobol_seq_gen.sv
// Directed and randomised bench for sobol_seq_gen with a queue scoreboard of
// expected points built from an independent recurrence model.
module tb_sobol_seq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        dir_we;
    logic [4:0]  dir_addr;
    logic [31:0] dir_wdata;
    logic        start;
    logic [31:0] num_pts;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_v [32];
    logic [31:0] exp_q [$];

    sobol_seq_gen dut (
        .clk       (clk),
        .rst       (rst),
        .dir_we    (dir_we),
        .dir_addr  (dir_addr),
        .dir_wdata (dir_wdata),
        .start     (start),
        .num_pts   (num_pts),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_default();
        for (int k = 0; k < 32; k++) model_v[k] = 32'h8000_0000 >> k;
    endtask

    // Index of lowest zero bit of i: i ^ (i+1) is a run of c+1 ones.
    task automatic push_model(input int unsigned n);
        logic [31:0] x;
        int unsigned c;
        x = model_v[0];
        for (int unsigned i = 1; i <= n; i++) begin
            exp_q.push_back(x);
            c = $countones(i ^ (i + 1)) - 1;
            x = x ^ model_v[c];
        end
    endtask

    task automatic write_dir(input logic [4:0] a, input logic [31:0] d);
        dir_we = 1'b1; dir_addr = a; dir_wdata = d;
        model_v[a] = d;
        @(negedge clk);
        dir_we = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] n);
        start = 1'b1; num_pts = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: 3-cycle stall on point 2,
    // 3: ready high with a start+dir_we pulse injected after two points.
    task automatic drain(input int mode, input int n_pts);
        int          cyc = 0;
        int          pops = 0;
        int          stall = 0;
        bit          got_done = 0;
        bit          injected = 0;
        bit          prev_stalled = 0;
        bit          rdy;
        logic [31:0] prev = '0;
        for (int k = 0; k < 2000 && !got_done; k++) begin
            if (done) begin
                got_done = 1;
                if (mode == 0) check("done_latency", 32'(cyc), 32'(n_pts));
                check("done_no_valid", {31'b0, out_valid}, 32'd0);
                check("done_busy", {31'b0, busy}, 32'd1);
                check("queue_empty", 32'(exp_q.size()), 32'd0);
            end else begin
                case (mode)
                    1:       rdy = ($urandom % 4) != 0;
                    2:       rdy = !(pops == 1 && stall < 3);
                    default: rdy = 1'b1;
                endcase
                if (mode == 3 && pops == 2 && !injected) begin
                    injected = 1;
                    start = 1'b1; num_pts = 32'd99;
                    dir_we = 1'b1; dir_addr = 5'd0; dir_wdata = 32'h1234_5678;
                end else begin
                    start = 1'b0; dir_we = 1'b0;
                end
                out_ready = rdy;
                if (prev_stalled) check("hold_data", out_data, prev);
                check("valid", {31'b0, out_valid}, 32'd1);
                check("busy", {31'b0, busy}, 32'd1);
                if (exp_q.size() > 0) begin
                    check("last", {31'b0, out_last}, {31'b0, exp_q.size() == 1});
                    if (mode == 2 && !rdy) begin
                        stall++;
                        check("stall_data", out_data, 32'hC000_0000);
                    end
                    if (rdy) begin
                        check("data", out_data, exp_q.pop_front());
                        pops++;
                    end
                end
                prev_stalled = !rdy;
                prev = out_data;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; dir_we = 1'b0; out_ready = 1'b1;
        tests++;
        assert (got_done) else begin
            fails++;
            $error("FAIL run_timeout: observed done=0 expected done=1");
        end
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_done", {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; dir_we = 1'b0; dir_addr = '0; dir_wdata = '0;
        start = 1'b0; num_pts = '0; out_ready = 1'b1;
        model_default();
        repeat (3) @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Van der Corput points from the default table.
        exp_q.push_back(32'h8000_0000); exp_q.push_back(32'hC000_0000);
        exp_q.push_back(32'h4000_0000); exp_q.push_back(32'h6000_0000);
        start_run(32'd4);
        drain(0, 4);

        write_dir(5'd0, 32'h0332_0000);
        write_dir(5'd1, 32'h06C4_0000);
        exp_q.push_back(32'h0332_0000); exp_q.push_back(32'h05F6_0000);
        exp_q.push_back(32'h06C4_0000);
        start_run(32'd3);
        drain(0, 3);

        // Mid-run reset with a custom table loaded.
        start_run(32'd10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_last", {31'b0, out_last}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        model_default();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'h8000_0000); exp_q.push_back(32'hC000_0000);
        exp_q.push_back(32'h4000_0000); exp_q.push_back(32'h6000_0000);
        start_run(32'd4);
        drain(0, 4);

        push_model(8);
        start_run(32'd8);
        drain(2, 8);

        start_run(32'd0);
        drain(0, 0);

        // Mid-run start/dir_we must be ignored; a follow-up run proves v[0] is untouched.
        push_model(6);
        start_run(32'd6);
        drain(3, 6);
        exp_q.push_back(32'h8000_0000); exp_q.push_back(32'hC000_0000);
        start_run(32'd2);
        drain(0, 2);

        for (int r = 0; r < 4; r++) begin
            int unsigned np;
            for (int k = 0; k < 32; k++) write_dir(5'(k), $urandom);
            np = $urandom_range(64, 1);
            push_model(np);
            start_run(np);
            drain(1, int'(np));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
